beat_sounder: RTL and testbench

- Downstream consumer of the metronome beat generator's BEEP output.
- Detects each new beat and tracks beat position within a bar.
- Drives a square-wave speaker tone for a fixed duration per beat: high pitch on the downbeat (accent), low pitch on other beats.
- Sits between the beat generator and the board's speaker/GPIO pin.

---
 rtl/beat_sounder.sv | 121 ++++++++++++
 tb/tb_beat_sounder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/beat_sounder.sv
// Beat sounder: detects rising edges of the beat generator's BEEP level, tracks the position
// within the bar and plays a fixed-length square-wave tone per beat (high pitch on downbeat).
module beat_sounder #(
  parameter int unsigned ACCENT_HALF_PERIOD = 14205,
  parameter int unsigned NORMAL_HALF_PERIOD = 28409,
  parameter int unsigned TONE_CYCLES        = 2500000
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       BEEP,
  input  logic [3:0] BEATS_PER_BAR,
  input  logic       MUTE,
  output logic       SPEAKER,
  output logic       TONE_ACTIVE,
  output logic       ACCENT,
  output logic [3:0] BEAT_NUM
);

  localparam int unsigned HalfMax = (ACCENT_HALF_PERIOD > NORMAL_HALF_PERIOD) ?
                                    ACCENT_HALF_PERIOD : NORMAL_HALF_PERIOD;
  localparam int unsigned DurW    = (TONE_CYCLES > 1) ? $clog2(TONE_CYCLES) : 1;
  localparam int unsigned HalfW   = (HalfMax > 1) ? $clog2(HalfMax) : 1;

  typedef enum logic {StIdle, StTone} state_e;

  state_e            state_q;
  logic              sync1_q, sync2_q, sync3_q;
  logic              first_q;
  logic [3:0]        beat_num_q, beat_num_d;
  logic              accent_q;
  logic              tone_active_q;
  logic              phase_q;
  logic              speaker_q;
  logic [DurW-1:0]   dur_q;
  logic [HalfW-1:0]  half_q;
  logic [HalfW-1:0]  half_last;
  logic              beat_evt;

  assign beat_evt  = sync2_q & ~sync3_q;
  // Pitch of the tone in progress follows the registered accent flag.
  assign half_last = accent_q ? HalfW'(ACCENT_HALF_PERIOD - 1) : HalfW'(NORMAL_HALF_PERIOD - 1);

  always_comb begin
    beat_num_d = beat_num_q + 4'd1;
    if (first_q || (BEATS_PER_BAR <= 4'd1) || (beat_num_q >= BEATS_PER_BAR - 4'd1)) begin
      beat_num_d = 4'd0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= BEEP;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q       <= StIdle;
      first_q       <= 1'b1;
      beat_num_q    <= 4'd0;
      accent_q      <= 1'b0;
      tone_active_q <= 1'b0;
      phase_q       <= 1'b0;
      dur_q         <= '0;
      half_q        <= '0;
    end else if (beat_evt) begin
      // A new beat always (re)starts the tone, including on the expiry edge.
      state_q       <= StTone;
      first_q       <= 1'b0;
      beat_num_q    <= beat_num_d;
      accent_q      <= (beat_num_d == 4'd0);
      tone_active_q <= 1'b1;
      phase_q       <= 1'b1;
      dur_q         <= '0;
      half_q        <= '0;
    end else begin
      case (state_q)
        StTone: begin
          if (dur_q == DurW'(TONE_CYCLES - 1)) begin
            state_q       <= StIdle;
            tone_active_q <= 1'b0;
            phase_q       <= 1'b0;
            dur_q         <= '0;
            half_q        <= '0;
          end else begin
            dur_q <= dur_q + 1'b1;
            if (half_q == half_last) begin
              half_q  <= '0;
              phase_q <= ~phase_q;
            end else begin
              half_q <= half_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      speaker_q <= 1'b0;
    end else begin
      speaker_q <= phase_q & ~MUTE;
    end
  end

  assign SPEAKER     = speaker_q;
  assign TONE_ACTIVE = tone_active_q;
  assign ACCENT      = accent_q;
  assign BEAT_NUM    = beat_num_q;

endmodule

// File: tb/tb_beat_sounder.sv
// Directed bench for beat_sounder with short tone parameters (accent 2, normal 4, tone 20).
module tb_beat_sounder;

  logic       CLOCK_50;
  logic       RESET_N;
  logic       BEEP;
  logic [3:0] BEATS_PER_BAR;
  logic       MUTE;
  logic       SPEAKER;
  logic       TONE_ACTIVE;
  logic       ACCENT;
  logic [3:0] BEAT_NUM;

  int unsigned checks = 0;
  int unsigned errors = 0;

  beat_sounder #(
    .ACCENT_HALF_PERIOD(2),
    .NORMAL_HALF_PERIOD(4),
    .TONE_CYCLES       (20)
  ) dut (
    .CLOCK_50     (CLOCK_50),
    .RESET_N      (RESET_N),
    .BEEP         (BEEP),
    .BEATS_PER_BAR(BEATS_PER_BAR),
    .MUTE         (MUTE),
    .SPEAKER      (SPEAKER),
    .TONE_ACTIVE  (TONE_ACTIVE),
    .ACCENT       (ACCENT),
    .BEAT_NUM     (BEAT_NUM)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1ns past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {25'd0, SPEAKER, TONE_ACTIVE, ACCENT, BEAT_NUM}, 32'd0);
  endtask

  // Raise BEEP so it is sampled at the next edge k; returns just after edge k+2.
  task automatic beat(input string tag, input logic [3:0] exp_num, input logic exp_acc);
    BEEP = 1'b1;
    step(3);
    check({tag, "_active"}, {31'd0, TONE_ACTIVE}, 32'd1);
    check({tag, "_num"}, {28'd0, BEAT_NUM}, {28'd0, exp_num});
    check({tag, "_accent"}, {31'd0, ACCENT}, {31'd0, exp_acc});
    BEEP = 1'b0;
  endtask

  initial begin
    RESET_N       = 1'b0;
    BEEP          = 1'b0;
    BEATS_PER_BAR = 4'd4;
    MUTE          = 1'b0;

    // Reset held while BEEP toggles.
    for (int i = 0; i < 6; i++) begin
      BEEP = ~BEEP;
      step(1);
      check_all_zero("reset_hold");
    end
    BEEP = 1'b0;
    step(1);
    RESET_N = 1'b1;
    step(5);
    check_all_zero("after_release");

    // Downbeat, BEEP held high for 50 clocks.
    BEEP = 1'b1;
    step(3);
    check("down_active", {31'd0, TONE_ACTIVE}, 32'd1);
    check("down_accent", {31'd0, ACCENT}, 32'd1);
    check("down_num", {28'd0, BEAT_NUM}, 32'd0);
    check("down_spk_k2", {31'd0, SPEAKER}, 32'd0);
    step(1);
    check("down_spk_k3", {31'd0, SPEAKER}, 32'd1);
    step(1);
    check("down_spk_k4", {31'd0, SPEAKER}, 32'd1);
    step(1);
    check("down_spk_k5", {31'd0, SPEAKER}, 32'd0);
    step(1);
    check("down_spk_k6", {31'd0, SPEAKER}, 32'd0);
    step(1);
    check("down_spk_k7", {31'd0, SPEAKER}, 32'd1);
    step(14);
    check("down_active_k21", {31'd0, TONE_ACTIVE}, 32'd1);
    step(1);
    check("down_active_k22", {31'd0, TONE_ACTIVE}, 32'd0);
    step(1);
    check("down_spk_end", {31'd0, SPEAKER}, 32'd0);
    step(26);
    check("down_single_tone", {31'd0, TONE_ACTIVE}, 32'd0);
    BEEP = 1'b0;
    step(5);

    // Bar counting from a fresh reset.
    RESET_N = 1'b0;
    step(2);
    RESET_N = 1'b1;
    step(2);
    for (int i = 0; i < 9; i++) begin
      beat($sformatf("bar%0d", i), 4'(i % 4), (i % 4) == 0);
      if (i == 1) begin
        step(1);
        check("normal_spk_k3", {31'd0, SPEAKER}, 32'd1);
        step(3);
        check("normal_spk_k6", {31'd0, SPEAKER}, 32'd1);
        step(1);
        check("normal_spk_k7", {31'd0, SPEAKER}, 32'd0);
        step(92);
      end else begin
        step(97);
      end
    end

    // Retrigger 10 clocks into a normal tone.
    beat("retrig_first", 4'd1, 1'b0);
    step(8);
    BEEP = 1'b1;
    step(1);
    check("retrig_active_a", {31'd0, TONE_ACTIVE}, 32'd1);
    step(1);
    check("retrig_active_b", {31'd0, TONE_ACTIVE}, 32'd1);
    step(1);
    check("retrig_num", {28'd0, BEAT_NUM}, 32'd2);
    check("retrig_active_r", {31'd0, TONE_ACTIVE}, 32'd1);
    BEEP = 1'b0;
    step(1);
    check("retrig_spk_r1", {31'd0, SPEAKER}, 32'd1);
    step(3);
    check("retrig_spk_r4", {31'd0, SPEAKER}, 32'd1);
    step(1);
    check("retrig_spk_r5", {31'd0, SPEAKER}, 32'd0);
    step(5);
    check("retrig_active_r10", {31'd0, TONE_ACTIVE}, 32'd1);
    step(9);
    check("retrig_active_r19", {31'd0, TONE_ACTIVE}, 32'd1);
    step(1);
    check("retrig_active_r20", {31'd0, TONE_ACTIVE}, 32'd0);
    step(30);

    // Meter lowered below current position.
    beat("meter_pos3", 4'd3, 1'b0);
    step(40);
    BEATS_PER_BAR = 4'd2;
    beat("meter_wrap", 4'd0, 1'b1);
    step(40);
    check("accent_hold_idle", {31'd0, ACCENT}, 32'd1);
    beat("meter_two", 4'd1, 1'b0);
    step(40);

    // Muted, every beat accented.
    MUTE          = 1'b1;
    BEATS_PER_BAR = 4'd0;
    beat("mute_a", 4'd0, 1'b1);
    for (int i = 0; i < 17; i++) begin
      step(1);
      check("mute_spk", {31'd0, SPEAKER}, 32'd0);
    end
    check("mute_active_r17", {31'd0, TONE_ACTIVE}, 32'd1);
    step(2);
    check("mute_active_r19", {31'd0, TONE_ACTIVE}, 32'd1);
    step(1);
    check("mute_active_r20", {31'd0, TONE_ACTIVE}, 32'd0);
    step(20);

    // Beat landing exactly on the expiry edge keeps the tone going.
    beat("mute_b", 4'd0, 1'b1);
    step(17);
    BEEP = 1'b1;
    step(3);
    check("expiry_retrig_active", {31'd0, TONE_ACTIVE}, 32'd1);
    check("expiry_retrig_num", {28'd0, BEAT_NUM}, 32'd0);
    check("expiry_retrig_accent", {31'd0, ACCENT}, 32'd1);
    BEEP = 1'b0;
    step(19);
    check("expiry_active_39", {31'd0, TONE_ACTIVE}, 32'd1);
    step(1);
    check("expiry_active_40", {31'd0, TONE_ACTIVE}, 32'd0);
    check("expiry_spk_muted", {31'd0, SPEAKER}, 32'd0);
    step(20);

    // Reset mid-tone.
    MUTE          = 1'b0;
    BEATS_PER_BAR = 4'd4;
    beat("pre_reset", 4'd1, 1'b0);
    step(5);
    RESET_N = 1'b0;
    #1;
    check_all_zero("reset_midtone");
    step(3);
    check_all_zero("reset_midtone_hold");
    RESET_N = 1'b1;
    step(3);
    check_all_zero("reset_midtone_release");
    beat("post_reset", 4'd0, 1'b1);
    step(25);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
